// File: rtl/icache_mshr_downstream_arb.sv
// Round-robin arbiter that issues icache MSHR refill requests on the downstream txreq channel,
// tracks per-entry outstanding fills and routes returning rxdat beats back as fill-done pulses.
module icache_mshr_downstream_arb #(
  parameter int unsigned ENTRY_NUM       = 8,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned TXNID_WIDTH     = 5,
  parameter int unsigned OPCODE_WIDTH    = 5,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [ENTRY_NUM-1:0]                          entry_req_vld,
  input  logic [ENTRY_NUM*ADDR_WIDTH-1:0]               entry_req_addr,
  output logic [ENTRY_NUM-1:0]                          entry_req_gnt,
  output logic                                          downstream_txreq_vld,
  input  logic                                          downstream_txreq_rdy,
  output logic [OPCODE_WIDTH+TXNID_WIDTH+ADDR_WIDTH-1:0] downstream_txreq_pld,
  input  logic                                          downstream_rxdat_vld,
  input  logic [TXNID_WIDTH-1:0]                        downstream_rxdat_txnid,
  output logic [ENTRY_NUM-1:0]                          entry_fill_done,
  output logic [$clog2(ENTRY_NUM+1)-1:0]                outstanding_cnt,
  output logic                                          err_rxdat
);

  localparam int unsigned IDX_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
  localparam int unsigned CNT_W = $clog2(ENTRY_NUM + 1);
  localparam int unsigned PLD_W = OPCODE_WIDTH + TXNID_WIDTH + ADDR_WIDTH;
  localparam logic [OPCODE_WIDTH-1:0] DOWNSTREAM_OPCODE = OPCODE_WIDTH'(1);

  logic [ENTRY_NUM-1:0] inflight_q, inflight_d;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic                 txreq_vld_q;
  logic [PLD_W-1:0]     txreq_pld_q;
  logic [ENTRY_NUM-1:0] fill_done_q;
  logic                 err_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [ENTRY_NUM-1:0]   eligible;
  logic                   out_free;
  logic                   cap_ok;
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       scan_idx;
  logic                   grant;
  logic [ENTRY_NUM-1:0]   grant_mask;
  logic [TXNID_WIDTH-1:0] win_txnid;
  logic [ADDR_WIDTH-1:0]  win_addr;

  logic                 rx_in_range;
  logic [IDX_W-1:0]     rx_idx;
  logic                 rx_hit;
  logic                 rx_err;
  logic [ENTRY_NUM-1:0] fill_mask;

  // Eligibility uses registered inflight, so a same-cycle fill re-enables the entry next cycle.
  assign eligible = entry_req_vld & ~inflight_q;
  assign out_free = ~txreq_vld_q | downstream_txreq_rdy;
  assign cap_ok   = int'(cnt_q) < int'(MAX_OUTSTANDING);

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < int'(ENTRY_NUM); k++) begin
      scan_idx = rr_ptr_q + IDX_W'(k);
      if (!win_found && eligible[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign grant         = win_found & out_free & cap_ok & ~rst;
  assign grant_mask    = grant ? (ENTRY_NUM'(1) << win_idx) : '0;
  assign entry_req_gnt = grant_mask;
  assign win_addr      = entry_req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];

  always_comb begin
    win_txnid            = '0;
    win_txnid[IDX_W-1:0] = win_idx;
  end

  assign rx_in_range = int'(downstream_rxdat_txnid) < int'(ENTRY_NUM);
  assign rx_idx      = downstream_rxdat_txnid[IDX_W-1:0];
  assign rx_hit      = downstream_rxdat_vld & rx_in_range & inflight_q[rx_idx];
  assign rx_err      = downstream_rxdat_vld & ~rx_hit;
  assign fill_mask   = rx_hit ? (ENTRY_NUM'(1) << rx_idx) : '0;

  // Grant and fill never hit the same entry: grant needs ~inflight, fill needs inflight.
  assign inflight_d = (inflight_q & ~fill_mask) | grant_mask;

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < int'(ENTRY_NUM); i++) begin
      cnt_d = cnt_d + CNT_W'(inflight_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q  <= '0;
      rr_ptr_q    <= '0;
      txreq_vld_q <= 1'b0;
      txreq_pld_q <= '0;
      fill_done_q <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      inflight_q  <= inflight_d;
      cnt_q       <= cnt_d;
      fill_done_q <= fill_mask;
      err_q       <= rx_err;
      if (grant) begin
        rr_ptr_q    <= win_idx + IDX_W'(1);
        txreq_vld_q <= 1'b1;
        txreq_pld_q <= {DOWNSTREAM_OPCODE, win_txnid, win_addr};
      end else if (txreq_vld_q && downstream_txreq_rdy) begin
        txreq_vld_q <= 1'b0;
      end
    end
  end

  assign downstream_txreq_vld = txreq_vld_q;
  assign downstream_txreq_pld = txreq_pld_q;
  assign entry_fill_done      = fill_done_q;
  assign err_rxdat            = err_q;
  assign outstanding_cnt      = cnt_q;

endmodule
